// File: rtl/cam_power_seq_if.sv
// Sensor control bundle between top-level control and the power sequencer.
// Control requests flow in; pin drives and status flow out.
interface cam_power_seq_if;
    logic       enable;
    logic       restart;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       ready;
    logic       busy;
    logic [2:0] state;
    logic       led;

    modport master (
        output enable, restart,
        input  cam_pwdn, cam_rst_n, ready, busy, state, led
    );

    modport slave (
        input  enable, restart,
        output cam_pwdn, cam_rst_n, ready, busy, state, led
    );
endinterface

// File: rtl/cam_power_seq.sv
// Camera sensor power-up sequencer: OFF -> PWRUP -> RESET -> SETTLE -> READY.
// All pin and status outputs are registered alongside the state.
module cam_power_seq #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned T_PWR    = 1190,
    parameter int unsigned T_RST    = 4760,
    parameter int unsigned T_SETTLE = 79968,
    parameter int unsigned LED_DIV  = 22
) (
    input  logic          xvclk,
    input  logic          resetb,
    cam_power_seq_if.slave cam
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWRUP  = 3'd1,
        S_RESET  = 3'd2,
        S_SETTLE = 3'd3,
        S_READY  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] STL_LAST = CNT_W'(T_SETTLE - 1);
    localparam int unsigned      LB       = LED_DIV - 1;

    state_t             st, st_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [LED_DIV-1:0] div, div_nx;
    logic               pwdn, pwdn_nx;
    logic               rstn, rstn_nx;
    logic               rdy, rdy_nx;
    logic               bsy, bsy_nx;
    logic               led, led_nx;
    logic               timed;
    logic               entry;
    logic               tgl;

    always_comb begin
        st_nx   = st;
        pwdn_nx = 1'b1;
        rstn_nx = 1'b0;
        rdy_nx  = 1'b0;
        bsy_nx  = 1'b0;
        led_nx  = 1'b0;

        unique case (st)
            S_OFF:    if (cam.enable) st_nx = S_PWRUP;
            S_PWRUP:  if (cnt == PWR_LAST) st_nx = S_RESET;
            S_RESET:  if (cnt == RST_LAST) st_nx = S_SETTLE;
            S_SETTLE: if (cnt == STL_LAST) st_nx = S_READY;
            S_READY:  if (cam.restart) st_nx = S_RESET;
            default:  st_nx = S_OFF;
        endcase
        if (!cam.enable) st_nx = S_OFF;

        timed  = (st == S_PWRUP) || (st == S_RESET) || (st == S_SETTLE);
        cnt_nx = (timed && st_nx == st) ? cnt + 1'b1 : '0;

        // Entering PWRUP or RESET restarts the blink phase.
        entry  = (st_nx != st) && (st_nx == S_PWRUP || st_nx == S_RESET);
        div_nx = entry ? '0 : div + 1'b1;
        tgl    = !entry && (div_nx[LB] != div[LB]);

        unique case (st_nx)
            S_PWRUP: begin
                bsy_nx = 1'b1;
                led_nx = led ^ tgl;
            end
            S_RESET: begin
                pwdn_nx = 1'b0;
                bsy_nx  = 1'b1;
                led_nx  = led ^ tgl;
            end
            S_SETTLE: begin
                pwdn_nx = 1'b0;
                rstn_nx = 1'b1;
                bsy_nx  = 1'b1;
                led_nx  = led ^ tgl;
            end
            S_READY: begin
                pwdn_nx = 1'b0;
                rstn_nx = 1'b1;
                rdy_nx  = 1'b1;
                led_nx  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge xvclk) begin
        if (resetb) begin
            st   <= S_OFF;
            cnt  <= '0;
            div  <= '0;
            pwdn <= 1'b1;
            rstn <= 1'b0;
            rdy  <= 1'b0;
            bsy  <= 1'b0;
            led  <= 1'b0;
        end else begin
            st   <= st_nx;
            cnt  <= cnt_nx;
            div  <= div_nx;
            pwdn <= pwdn_nx;
            rstn <= rstn_nx;
            rdy  <= rdy_nx;
            bsy  <= bsy_nx;
            led  <= led_nx;
        end
    end

    assign cam.state     = st;
    assign cam.cam_pwdn  = pwdn;
    assign cam.cam_rst_n = rstn;
    assign cam.ready     = rdy;
    assign cam.busy      = bsy;
    assign cam.led       = led;

endmodule

// File: tb/tb_cam_power_seq.sv
// Bench for cam_power_seq: per-cycle vector table through a scoreboard queue,
// plus a short hand sequence on a second instance with one-cycle durations.
module tb_cam_power_seq;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rs;
        logic [2:0] st;
        logic       led;
    } vec_t;

    typedef struct {
        string      name;
        int         idx;
        logic [7:0] val;
    } exp_t;

    logic xvclk = 1'b0;
    logic rst0  = 1'b1;
    logic rst1  = 1'b1;

    vec_t tbl[$];
    exp_t sb0[$];
    exp_t sb1[$];
    int   total = 0;
    int   pass  = 0;

    cam_power_seq_if u_if0 ();
    cam_power_seq_if u_if1 ();

    cam_power_seq #(
        .CNT_W(32), .T_PWR(4), .T_RST(3), .T_SETTLE(5), .LED_DIV(2)
    ) u_dut0 (
        .xvclk  (xvclk),
        .resetb (rst0),
        .cam    (u_if0.slave)
    );

    cam_power_seq #(
        .CNT_W(32), .T_PWR(1), .T_RST(1), .T_SETTLE(1), .LED_DIV(2)
    ) u_dut1 (
        .xvclk  (xvclk),
        .resetb (rst1),
        .cam    (u_if1.slave)
    );

    always #5 xvclk = ~xvclk;

    // {state, cam_pwdn, cam_rst_n, ready, busy, led} expected for a state
    function automatic logic [7:0] outs(logic [2:0] st, logic led);
        logic [3:0] p;
        case (st)
            3'd0:    p = 4'b1000;
            3'd1:    p = 4'b1001;
            3'd2:    p = 4'b0001;
            3'd3:    p = 4'b0101;
            3'd4:    p = 4'b0110;
            default: p = 4'b1000;
        endcase
        return {st, p, led};
    endfunction

    function automatic void add(int n, logic r, logic e, logic s,
                                logic [2:0] st, logic led);
        vec_t v;
        v.rst = r; v.en = e; v.rs = s; v.st = st; v.led = led;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    function automatic void check(exp_t e, logic [7:0] act);
        total++;
        if (act === e.val) pass++;
        else $display("FAIL %s[%0d]: got %b, expected %b (st,pwdn,rstn,rdy,busy,led)",
                      e.name, e.idx, act, e.val);
    endfunction

    task automatic step1(logic r, logic e, logic s, logic [2:0] st,
                         logic led, int idx);
        exp_t x;
        rst1 = r;
        u_if1.enable = e;
        u_if1.restart = s;
        x.name = "degen"; x.idx = idx; x.val = outs(st, led);
        sb1.push_back(x);
        @(posedge xvclk);
        #1;
        x = sb1.pop_front();
        check(x, {u_if1.state, u_if1.cam_pwdn, u_if1.cam_rst_n,
                  u_if1.ready, u_if1.busy, u_if1.led});
    endtask

    initial begin
        exp_t x;
        u_if0.enable = 1'b1; u_if0.restart = 1'b1;
        u_if1.enable = 1'b0; u_if1.restart = 1'b0;

        // reset with inputs active, then idle in OFF until edge 10
        add(2, 1, 1, 1, 0, 0);
        add(7, 0, 0, 0, 0, 0);
        // nominal power-up, edges 10..23
        add(1,0,1,0,1,0); add(1,0,1,0,1,0); add(1,0,1,0,1,1); add(1,0,1,0,1,1);
        add(1,0,1,0,2,1); add(1,0,1,0,2,1); add(1,0,1,0,2,0);
        add(1,0,1,0,3,0); add(1,0,1,0,3,1); add(1,0,1,0,3,1);
        add(1,0,1,0,3,0); add(1,0,1,0,3,0);
        add(2,0,1,0,4,1);
        // restart from READY
        add(1,0,1,1,2,1); add(1,0,1,0,2,1); add(1,0,1,0,2,0);
        add(1,0,1,0,3,0); add(1,0,1,0,3,1); add(1,0,1,0,3,1);
        add(1,0,1,0,3,0); add(1,0,1,0,3,0); add(1,0,1,0,4,1);
        // restart again, then a restart in SETTLE that must be ignored
        add(1,0,1,1,2,1); add(1,0,1,0,2,1); add(1,0,1,0,2,0);
        add(1,0,1,0,3,0); add(1,0,1,1,3,1); add(1,0,1,0,3,1);
        add(1,0,1,0,3,0); add(1,0,1,0,3,0); add(1,0,1,0,4,1);
        // restart together with enable low
        add(1,0,0,1,0,0); add(1,0,0,0,0,0);
        // enable drop at SETTLE count 2
        add(1,0,1,0,1,0); add(1,0,1,0,1,0); add(1,0,1,0,1,1); add(1,0,1,0,1,1);
        add(1,0,1,0,2,1); add(1,0,1,0,2,1); add(1,0,1,0,2,0);
        add(1,0,1,0,3,0); add(1,0,1,0,3,1); add(1,0,1,0,3,1);
        add(1,0,0,0,0,0);
        // re-enable: full PWRUP, then reset during RESET
        add(1,0,1,0,1,0); add(1,0,1,0,1,0); add(1,0,1,0,1,1); add(1,0,1,0,1,1);
        add(1,0,1,0,2,1);
        add(2,1,1,0,0,0);
        // full sequence after reset release
        add(1,0,1,0,1,0); add(1,0,1,0,1,0); add(1,0,1,0,1,1); add(1,0,1,0,1,1);
        add(1,0,1,0,2,1); add(1,0,1,0,2,1); add(1,0,1,0,2,0);
        add(1,0,1,0,3,0); add(1,0,1,0,3,1); add(1,0,1,0,3,1);
        add(1,0,1,0,3,0); add(1,0,1,0,3,0);
        add(2,0,1,0,4,1);
        add(1,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst0 = tbl[i].rst;
            u_if0.enable = tbl[i].en;
            u_if0.restart = tbl[i].rs;
            x.name = "main"; x.idx = i + 1;
            x.val = outs(tbl[i].st, tbl[i].led);
            sb0.push_back(x);
            @(posedge xvclk);
            #1;
            x = sb0.pop_front();
            check(x, {u_if0.state, u_if0.cam_pwdn, u_if0.cam_rst_n,
                      u_if0.ready, u_if0.busy, u_if0.led});
        end

        // one-cycle durations: READY three edges after enable
        step1(1, 1, 0, 0, 0, 0);
        step1(0, 1, 0, 1, 0, 1);
        step1(0, 1, 0, 2, 0, 2);
        step1(0, 1, 0, 3, 0, 3);
        step1(0, 1, 0, 4, 1, 4);
        step1(0, 1, 0, 4, 1, 5);
        step1(0, 1, 1, 2, 1, 6);
        step1(0, 1, 0, 3, 1, 7);
        step1(0, 1, 0, 4, 1, 8);
        step1(0, 0, 0, 0, 0, 9);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
